pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Architectural PC register and next-PC selection for the single-cycle core.
//  Drives PC to instruction memory and to the combinational PC+1 incrementer.
//  Consumes the incrementer's PCPlus1 and picks the next PC each clock:
//  sequential, branch, or jump.
//  Small RUN/HALT controller handles stall and halt/resume.
// PARAMETERS
//  RESET_VECTOR  32'sd0  PC value loaded on reset (word address)
//  RAS_DEPTH     4       return-address-stack entries (PC_RAS_EN only), power of 2, 2..16
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  pc_plus1       in   32  signed PC+1 from incrementer (word address)
//  stall          in   1   hold PC this cycle
//  branch_taken   in   1   conditional branch resolved taken
//  branch_offset  in   32  signed word offset, relative to pc_plus1
//  jump           in   1   absolute jump
//  jump_target    in   32  signed absolute jump address
//  halt           in   1   HALT instruction decoded
//  resume         in   1   leave HALT state
//  call           in   1   jump and push return address (PC_RAS_EN only)
//  ret            in   1   pop return address (PC_RAS_EN only)
//  pc             out  32  signed current PC
//  pc_valid       out  1   pc holds an instruction to execute
//  halted         out  1   controller in HALT
//  ras_err        out  1   RAS underflow/overflow pulse (PC_RAS_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0,
//    ras_err=0, RAS pointer=0. Reset overrides all other inputs, in any state.
//  - BOOT: one cycle after rst deasserts. pc holds, pc_valid=0. Then -> RUN.
//  - RUN: pc_valid=1. Next PC on each edge, highest priority first:
//      1 stall                  -> pc holds, state holds
//      2 halt                   -> pc holds, -> HALT
//      3 jump (or call)         -> pc=jump_target
//      4 branch_taken           -> pc=pc_plus1+branch_offset
//      5 otherwise              -> pc=pc_plus1
//  - HALT: pc holds, pc_valid=0, halted=1.
//      resume=1 -> RUN next edge, pc=pc_plus1 (skips the HALT word).
//      All other inputs ignored.
//      resume in RUN or BOOT is ignored.
//  - Latency: every select takes effect on the next rising edge; no bubbles.
//  - Arithmetic: 32-bit two's complement, wraps modulo 2^32, no saturation.
//    Overflow is not flagged.
//    pc_plus1=32'h7FFFFFFF + offset 1 -> 32'h80000000.
//  - pc_plus1 is trusted as PC+1; the block does not recompute or check it.
//  - branch_taken and jump both high: jump wins.
//    halt and jump both high: halt wins; jump is lost.
// CONFIGURATION
//  PC_RAS_EN defined:
//  - Return-address stack with RAS_DEPTH entries, circular, 32-bit each.
//  - Priority: call and ret sit at level 3, ahead of jump.
//  - call: push pc_plus1, pc=jump_target.
//    Push when full overwrites the oldest entry and pulses ras_err for 1 cycle.
//  - ret: pop, pc=popped value.
//    Pop when empty gives pc=pc_plus1 and pulses ras_err for 1 cycle.
//  - call and ret together: ret wins, call ignored, ras_err pulses.
//  - Stall, halt, and the HALT state block all push/pop.
//  - Reset empties the stack.
//  PC_RAS_EN undefined: call and ret are ignored, ras_err is tied 0, no stack
//  storage.
// TESTING
//  1 rst 2 cycles, RESET_VECTOR=0x100, then free-run.
//    -> pc=0x100, valid=0 one cycle; then 0x101, 0x102, valid=1.
//  2 pc=0x20, branch_taken, offset=-5.
//    -> next pc=0x1C. Same cycle with jump, target 0x400 -> pc=0x400.
//  3 stall 3 cycles at pc=0x50 with branch_taken asserted.
//    -> pc=0x50 throughout; branch applies on the first non-stall edge.
//  4 halt at pc=0x30 -> halted=1, valid=0, pc=0x30 held 10 cycles;
//    resume -> pc=0x31.
//  5 pc_plus1=0x7FFFFFFF, offset=+1 -> pc=0x80000000.
//    rst during HALT -> pc=RESET_VECTOR, halted=0.
//  6 PC_RAS_EN, RAS_DEPTH=4:
//    call from 0x10 to 0x200, then ret -> pc=0x11.
//    5 nested calls then 5 rets -> ras_err on the 5th call and the 5th ret.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC register, next-PC selection and BOOT/RUN/HALT controller for the single-cycle core.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_sequencer #(
  parameter logic signed [31:0] RESET_VECTOR = 32'sd0,
  parameter int unsigned        RAS_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] pc_plus1,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic signed [31:0] branch_offset,
  input  logic               jump,
  input  logic signed [31:0] jump_target,
  input  logic               halt,
  input  logic               resume,
  input  logic               call,
  input  logic               ret,
  output logic signed [31:0] pc,
  output logic               pc_valid,
  output logic               halted,
  output logic               ras_err
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] pc_q, pc_d;
  logic               pc_valid_q;
  logic               halted_q;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

  logic signed [31:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]   sp_q;
  logic [PTR_W:0]     cnt_q;
  logic               ras_err_q;
  logic [PTR_W-1:0]   top_idx;
  logic               ras_empty, ras_full;
  logic               push, pop, err_d;

  // sp_q points at the next free slot; when full that slot holds the oldest entry.
  assign top_idx   = sp_q - 1'b1;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_CNT);
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_call_ret;
  assign unused_call_ret = call ^ ret;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = ST_HALT;
`ifdef PC_RAS_EN
        end else if (ret) begin
          if (ras_empty) begin
            pc_d  = pc_plus1;
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ras_mem[top_idx];
          end
          if (call) err_d = 1'b1;
        end else if (call) begin
          push  = 1'b1;
          pc_d  = jump_target;
          err_d = ras_full;
`endif
        end else if (jump) begin
          pc_d = jump_target;
        end else if (branch_taken) begin
          pc_d = pc_plus1 + branch_offset;
        end else begin
          pc_d = pc_plus1;
        end
      end
      ST_HALT: begin
        // Resuming skips the HALT word itself.
        if (resume) begin
          state_d = ST_RUN;
          pc_d    = pc_plus1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= (state_d == ST_RUN);
      halted_q   <= (state_d == ST_HALT);
    end
  end

`ifdef PC_RAS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= err_d;
      if (push) begin
        sp_q <= sp_q + 1'b1;
        if (!ras_full) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        sp_q  <= top_idx;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // NOTE: stack storage is not reset; clearing the pointer and count is enough to empty it.
  always_ff @(posedge clk) begin
    if (push) ras_mem[sp_q] <= pc_plus1;
  end

  assign ras_err = ras_err_q;
`else
  assign ras_err = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// against a rule-level model (RAS scenarios active when PC_RAS_EN is defined).
module tb_pc_sequencer;

  localparam logic signed [31:0] RV    = 32'sh100;
  localparam int                 DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] pc_plus1, branch_offset, jump_target;
  logic               stall, branch_taken, jump, halt, resume, call, ret;
  logic signed [31:0] pc;
  logic               pc_valid, halted, ras_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic signed [31:0] m_pc;
  logic               m_valid, m_halted, m_err, m_boot;
  logic signed [31:0] m_ras[$];

  pc_sequencer #(.RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_plus1(pc_plus1), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
    .call(call), .ret(ret), .pc(pc), .pc_valid(pc_valid),
    .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // Applies the next-PC rules to the inputs present just before an edge.
  task automatic model_edge();
    m_err = 1'b0;
    if (rst) begin
      m_pc = RV; m_boot = 1'b1; m_valid = 1'b0; m_halted = 1'b0;
      m_ras.delete();
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else if (m_halted) begin
      if (resume) begin
        m_halted = 1'b0; m_valid = 1'b1; m_pc = pc_plus1;
      end
    end else if (stall) begin
      m_pc = m_pc;
    end else if (halt) begin
      m_halted = 1'b1; m_valid = 1'b0;
`ifdef PC_RAS_EN
    end else if (ret) begin
      if (m_ras.size() == 0) begin
        m_pc = pc_plus1; m_err = 1'b1;
      end else begin
        m_pc = m_ras.pop_back();
      end
      if (call) m_err = 1'b1;
    end else if (call) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
      m_ras.push_back(pc_plus1);
      m_pc = jump_target;
`endif
    end else if (jump) begin
      m_pc = jump_target;
    end else if (branch_taken) begin
      m_pc = pc_plus1 + branch_offset;
    end else begin
      m_pc = pc_plus1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    resume = 1'b0; call = 1'b0; ret = 1'b0;
    branch_offset = '0; jump_target = '0; pc_plus1 = m_pc + 1;
  endtask

  task automatic goto_pc(input logic signed [31:0] target);
    idle();
    jump = 1'b1; jump_target = target;
    tick();
    idle();
  endtask

  task automatic test_reset();
    m_pc = '0;
    idle();
    rst = 1'b1;
    tick(); tick();
    total++;
    if (pc !== 32'sh100 || pc_valid !== 1'b0 || halted !== 1'b0 || ras_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%h valid=%b halted=%b err=%b, want pc=00000100 valid=0 halted=0 err=0",
               pc, pc_valid, halted, ras_err);
    end
    idle(); pc_plus1 = 32'sh101;
    tick();
    total++;
    if (pc !== 32'sh100 || pc_valid !== 1'b1) begin
      bad++;
      $display("FAIL boot_exit: pc=%h valid=%b, want pc=00000100 valid=1", pc, pc_valid);
    end
    for (int i = 1; i <= 2; i++) begin
      pc_plus1 = 32'sh100 + i;
      tick();
      total++;
      if (pc !== 32'sh100 + i || pc_valid !== 1'b1) begin
        bad++;
        $display("FAIL free_run%0d: pc=%h valid=%b, want pc=%h valid=1", i, pc, pc_valid, 32'sh100 + i);
      end
    end
  endtask

  task automatic test_branch_jump();
    goto_pc(32'sh20);
    branch_taken = 1'b1; branch_offset = -32'sd5;
    tick();
    total++;
    if (pc !== 32'sh1C) begin
      bad++;
      $display("FAIL branch_neg: pc=%h want 0000001c", pc);
    end
    goto_pc(32'sh20);
    branch_taken = 1'b1; branch_offset = -32'sd5; jump = 1'b1; jump_target = 32'sh400;
    tick();
    total++;
    if (pc !== 32'sh400) begin
      bad++;
      $display("FAIL jump_over_branch: pc=%h want 00000400", pc);
    end
  endtask

  task automatic test_stall();
    goto_pc(32'sh50);
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'sh10;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc !== 32'sh50 || pc_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall%0d: pc=%h valid=%b, want pc=00000050 valid=1", i, pc, pc_valid);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (pc !== 32'sh61) begin
      bad++;
      $display("FAIL stall_release: pc=%h want 00000061", pc);
    end
  endtask

  task automatic test_halt();
    goto_pc(32'sh30);
    halt = 1'b1; jump = 1'b1; jump_target = 32'sh999;
    tick();
    total++;
    if (pc !== 32'sh30 || halted !== 1'b1 || pc_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_enter: pc=%h halted=%b valid=%b, want pc=00000030 halted=1 valid=0",
               pc, halted, pc_valid);
    end
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); branch_taken = 1'($urandom); jump = 1'($urandom);
      halt = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
      jump_target = $urandom; branch_offset = $urandom; pc_plus1 = $urandom;
      resume = 1'b0;
      tick();
      total++;
      if (pc !== 32'sh30 || halted !== 1'b1 || pc_valid !== 1'b0 || ras_err !== 1'b0) begin
        bad++;
        $display("FAIL halt_hold%0d: pc=%h halted=%b valid=%b err=%b, want 00000030/1/0/0",
                 i, pc, halted, pc_valid, ras_err);
      end
    end
    idle(); resume = 1'b1; pc_plus1 = 32'sh31;
    tick();
    total++;
    if (pc !== 32'sh31 || halted !== 1'b0 || pc_valid !== 1'b1) begin
      bad++;
      $display("FAIL resume: pc=%h halted=%b valid=%b, want pc=00000031 halted=0 valid=1",
               pc, halted, pc_valid);
    end
  endtask

  task automatic test_wrap_and_reset_in_halt();
    idle();
    pc_plus1 = 32'sh7FFFFFFF; branch_taken = 1'b1; branch_offset = 32'sd1;
    tick();
    total++;
    if (pc !== 32'sh80000000) begin
      bad++;
      $display("FAIL wrap: pc=%h want 80000000", pc);
    end
    idle(); halt = 1'b1;
    tick();
    idle(); rst = 1'b1;
    tick();
    total++;
    if (pc !== RV || halted !== 1'b0 || pc_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_halt: pc=%h halted=%b valid=%b, want pc=%h halted=0 valid=0",
               pc, halted, pc_valid, RV);
    end
    idle();
    tick();
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    goto_pc(32'sh10);
    call = 1'b1; jump_target = 32'sh200; pc_plus1 = 32'sh11;
    tick();
    total++;
    if (pc !== 32'sh200 || ras_err !== 1'b0) begin
      bad++;
      $display("FAIL call: pc=%h err=%b, want pc=00000200 err=0", pc, ras_err);
    end
    idle(); ret = 1'b1;
    tick();
    total++;
    if (pc !== 32'sh11 || ras_err !== 1'b0) begin
      bad++;
      $display("FAIL ret: pc=%h err=%b, want pc=00000011 err=0", pc, ras_err);
    end
    for (int i = 1; i <= 5; i++) begin
      idle(); call = 1'b1; jump_target = 32'sh1000 * i;
      tick();
      total++;
      if (pc !== 32'sh1000 * i || ras_err !== (i == 5)) begin
        bad++;
        $display("FAIL nest_call%0d: pc=%h err=%b, want pc=%h err=%b", i, pc, ras_err,
                 32'sh1000 * i, (i == 5));
      end
    end
    for (int i = 1; i <= 5; i++) begin
      idle(); ret = 1'b1;
      tick();
      total++;
      if (pc !== m_pc || ras_err !== (i == 5)) begin
        bad++;
        $display("FAIL nest_ret%0d: pc=%h err=%b, want pc=%h err=%b", i, pc, ras_err, m_pc, (i == 5));
      end
    end
  endtask
`else
  task automatic test_ras();
    goto_pc(32'sh10);
    call = 1'b1; jump_target = 32'sh200; pc_plus1 = 32'sh11;
    tick();
    total++;
    if (pc !== 32'sh11 || ras_err !== 1'b0) begin
      bad++;
      $display("FAIL call_ignored: pc=%h err=%b, want pc=00000011 err=0", pc, ras_err);
    end
    idle(); ret = 1'b1; pc_plus1 = 32'sh12;
    tick();
    total++;
    if (pc !== 32'sh12 || ras_err !== 1'b0) begin
      bad++;
      $display("FAIL ret_ignored: pc=%h err=%b, want pc=00000012 err=0", pc, ras_err);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      stall        = ($urandom_range(0, 99) < 15);
      halt         = ($urandom_range(0, 99) < 8);
      resume       = ($urandom_range(0, 99) < 30);
      jump         = ($urandom_range(0, 99) < 20);
      branch_taken = ($urandom_range(0, 99) < 30);
      call         = ($urandom_range(0, 99) < 15);
      ret          = ($urandom_range(0, 99) < 15);
      jump_target  = $urandom;
      branch_offset = $signed(32'($urandom_range(0, 64))) - 32'sd32;
      pc_plus1     = ($urandom_range(0, 9) == 0) ? $signed(32'($urandom)) : m_pc + 1;
      tick();
      total++;
      if (pc !== m_pc || pc_valid !== m_valid || halted !== m_halted || ras_err !== m_err) begin
        bad++;
        $display("FAIL random%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                 i, pc, pc_valid, halted, ras_err, m_pc, m_valid, m_halted, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch_jump();
    test_stall();
    test_halt();
    test_wrap_and_reset_in_halt();
    test_ras();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
